lif_tdm_scheduler: RTL and testbench
====================================

// Module: lif_tdm_scheduler
// PURPOSE
//  Time-multiplexed scheduler that shares one Q4.4 LIF update datapath among N_NEURONS virtual neurons.
//  Holds per-neuron membrane state (V, refractory) and a pending-input buffer.
//  On each tick, sweeps neurons 0..N-1 at one neuron per cycle.
//  Emits spike events (neuron id) through a valid/ready FIFO to the downstream router.
// PARAMETERS
//  N_NEURONS       8     virtual neuron count (>=2); IDW = $clog2(N_NEURONS)
//  THRESH_Q4_4     64    spike threshold, signed Q4.4 (+4.0)
//  LSH             3     leak shift: leak = V >>> LSH (arithmetic)
//  V_MAX_Q4_4      127   V loaded on spike
//  NEG_DRIVE_Q4_4  16    extra negative drive per update while refractory (1.0)
//  EVT_DEPTH       4     event FIFO depth; power of 2, >=2
// PORTS
//  clk          in   1    clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  en           in   1    sweep advance enable; en=0 freezes the sweep (state held)
//  tick         in   1    1-cycle pulse: start one sweep of all neurons
//  in_we        in   1    pending-input write strobe
//  in_addr      in   IDW  neuron index for in_we
//  in_data      in   8    signed Q4.4 input current; overwrites pending entry
//  rd_addr      in   IDW  debug read index
//  rd_v         out  8    V[rd_addr], combinational
//  rd_refr      out  1    refractory[rd_addr], combinational
//  evt_valid    out  1    event FIFO not empty
//  evt_id       out  IDW  neuron id at FIFO head
//  evt_ready    in   1    downstream accepts head when evt_valid & evt_ready
//  busy         out  1    high while in SWEEP
//  done         out  1    1-cycle pulse after the last neuron is committed
//  tick_overrun out  1    sticky: tick seen while busy; cleared only by reset
// BEHAVIOUR
//  Reset: all V=0, refractory=0, pending=0, FIFO empty.
//   All outputs: busy=0, done=0, evt_valid=0, tick_overrun=0.
//   Reset mid-sweep aborts the sweep; no partial-sweep state survives.
//  FSM:
//   IDLE --tick--> SWEEP with idx=0.
//   SWEEP: each cycle with en=1 and no stall, commits neuron idx, then idx++.
//   After idx=N-1 commits -> DONE (done=1 for 1 cycle) -> IDLE.
//   Latency: tick to done = N_NEURONS+1 cycles with no stalls.
//  Tick while SWEEP/DONE: ignored, tick_overrun<=1.
//  Update of neuron k (I = pending[k]; leak = V>>>LSH; sums 9-bit signed, sat8 to [-128,127]):
//   - refractory: Vn = sat8(V - leak - NEG_DRIVE); V<=Vn; clear refractory iff Vn <= -THRESH.
//   - else: Vn = sat8(V + I - leak).
//     If Vn >= THRESH: spike; V<=V_MAX; refractory<=1; push k into FIFO.
//     Otherwise V<=Vn.
//   - pending[k] <= 0 on commit (input consumed once; ignored if refractory).
//  Stall: neuron would spike and FIFO is full and no pop occurs this cycle -> hold idx, commit nothing.
//   Push and pop in the same cycle are both allowed when full.
//  in_we to the neuron being committed in the same cycle: write wins, value applies next sweep.
//   Other writes take effect immediately.
//  FIFO: first-word fall-through; events leave in push (= neuron index) order.
// CONFIGURATION
//  LIF_TDM_STATS_EN defined: adds output spike_cnt [15:0].
//   spike_cnt = total spikes pushed since reset, saturating at 16'hFFFF.
//  Without the macro: no counter and no port; behaviour otherwise identical.
// STRUCTURE
//  Package lif_pkg: Q4.4 width localparam, sat8 function, FSM state enum {IDLE,SWEEP,DONE}.
//  Sub-module lif_update_core (combinational): (V, refr, I) -> (Vn, refr_n, spike).
//   Per-neuron math lives only there.
//  FIFO stays inline.
// TESTING (N_NEURONS=4, defaults otherwise)
//  1 Reset: rd_v=0 all ids; busy=0; evt_valid=0.
//    Pulse tick -> busy for 4 cycles, done on cycle 5.
//  2 Integrate: in_data=32 to id2, tick -> V2=32, no event.
//    Tick again with no write -> V2=28 (input consumed).
//  3 Spike/refractory: in_data=80 to id1, tick -> event id1, V1=127, refractory=1.
//    Following ticks give V1 = 96,68,44,23,5,-11,-25,-37,-48,-58,-66.
//    Refractory clears at -66 (11th tick).
//  4 Backpressure: EVT_DEPTH=2, evt_ready=0, in_data=100 to all ids, tick.
//    -> 2 events queued, busy held at idx2.
//    Raise evt_ready -> ids 0,1,2,3 in order, then done.
//  5 Overrun/reset: tick during sweep -> tick_overrun=1, only one done.
//    rst_n low mid-sweep -> all state 0, busy=0.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared definitions for the LIF TDM scheduler: Q4.4 width, saturation helper, FSM states.
package lif_pkg;

  localparam int unsigned QW = 8;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

  // Clamp a 9-bit signed sum into the signed Q4.4 range [-128, 127].
  function automatic logic signed [QW-1:0] sat8(input logic signed [8:0] x);
    if (x > 9'sd127) begin
      return 8'h7F;
    end else if (x < -9'sd128) begin
      return 8'h80;
    end else begin
      return x[7:0];
    end
  endfunction

endpackage

// File: rtl/lif_tdm_scheduler_if.sv
// Spike event stream from the scheduler to the downstream router (valid/ready).
interface lif_tdm_scheduler_if #(
  parameter int unsigned IDW = 3
);
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/lif_update_core.sv
// Combinational Q4.4 leaky integrate-and-fire update for one neuron.
module lif_update_core
  import lif_pkg::*;
#(
  parameter int THRESH_Q4_4    = 64,
  parameter int LSH            = 3,
  parameter int V_MAX_Q4_4     = 127,
  parameter int NEG_DRIVE_Q4_4 = 16
) (
  input  logic signed [QW-1:0] v,
  input  logic                 refr,
  input  logic signed [QW-1:0] i_in,
  output logic signed [QW-1:0] v_n,
  output logic                 refr_n,
  output logic                 spike
);

  localparam logic signed [QW-1:0] THR     = 8'(THRESH_Q4_4);
  localparam logic signed [QW-1:0] NEG_THR = 8'(-THRESH_Q4_4);
  localparam logic signed [QW-1:0] VMAX    = 8'(V_MAX_Q4_4);
  localparam logic signed [8:0]    NDRV    = 9'(NEG_DRIVE_Q4_4);

  logic signed [8:0]    v_ext, i_ext, leak, sum_int, sum_ref;
  logic signed [QW-1:0] v_int, v_ref;

  assign v_ext   = {v[QW-1], v};
  assign i_ext   = {i_in[QW-1], i_in};
  assign leak    = v_ext >>> LSH;
  assign sum_int = v_ext + i_ext - leak;
  assign sum_ref = v_ext - leak - NDRV;
  assign v_int   = sat8(sum_int);
  assign v_ref   = sat8(sum_ref);

  // Refractory neurons ignore input and are driven down until far enough below rest.
  always_comb begin
    v_n    = v_int;
    refr_n = 1'b0;
    spike  = 1'b0;
    if (refr) begin
      v_n    = v_ref;
      refr_n = !(v_ref <= NEG_THR);
    end else if (v_int >= THR) begin
      v_n    = VMAX;
      refr_n = 1'b1;
      spike  = 1'b1;
    end
  end

endmodule

// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed LIF scheduler: one update core swept over N_NEURONS states per tick,
// spikes queued in a fall-through event FIFO.
// Optional feature macro LIF_TDM_STATS_EN adds a saturating spike counter output.
module lif_tdm_scheduler
  import lif_pkg::*;
#(
  parameter int unsigned N_NEURONS      = 8,
  parameter int          THRESH_Q4_4    = 64,
  parameter int          LSH            = 3,
  parameter int          V_MAX_Q4_4     = 127,
  parameter int          NEG_DRIVE_Q4_4 = 16,
  parameter int unsigned EVT_DEPTH      = 4,
  localparam int unsigned IDW           = $clog2(N_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   tick,
  input  logic                   in_we,
  input  logic [IDW-1:0]         in_addr,
  input  logic [QW-1:0]          in_data,
  input  logic [IDW-1:0]         rd_addr,
  output logic [QW-1:0]          rd_v,
  output logic                   rd_refr,
  lif_tdm_scheduler_if.master    evt,
  output logic                   busy,
  output logic                   done,
  output logic                   tick_overrun
`ifdef LIF_TDM_STATS_EN
  ,
  output logic [15:0]            spike_cnt
`endif
);

  localparam int unsigned    PW   = $clog2(EVT_DEPTH);
  localparam logic [IDW-1:0] LAST = IDW'(N_NEURONS - 1);

  state_e               state_q, state_d;
  logic [IDW-1:0]       idx_q, idx_d;
  logic                 overrun_q;
  logic signed [QW-1:0] v_q    [N_NEURONS];
  logic                 refr_q [N_NEURONS];
  logic signed [QW-1:0] pend_q [N_NEURONS];

  logic [IDW-1:0]       fifo_mem [EVT_DEPTH];
  logic [PW:0]          wr_ptr_q, rd_ptr_q;
  logic                 fifo_full, fifo_empty, push, pop, commit;

  logic signed [QW-1:0] v_n;
  logic                 refr_n, spike;

  lif_update_core #(
    .THRESH_Q4_4   (THRESH_Q4_4),
    .LSH           (LSH),
    .V_MAX_Q4_4    (V_MAX_Q4_4),
    .NEG_DRIVE_Q4_4(NEG_DRIVE_Q4_4)
  ) u_core (
    .v     (v_q[idx_q]),
    .refr  (refr_q[idx_q]),
    .i_in  (pend_q[idx_q]),
    .v_n   (v_n),
    .refr_n(refr_n),
    .spike (spike)
  );

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop        = evt.evt_valid && evt.evt_ready;
  // A spiking neuron stalls only if the FIFO is full and nothing drains this cycle.
  assign commit     = (state_q == SWEEP) && en && !(spike && fifo_full && !pop);
  assign push       = commit && spike;

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_id    = fifo_mem[rd_ptr_q[PW-1:0]];
  assign rd_v          = v_q[rd_addr];
  assign rd_refr       = refr_q[rd_addr];
  assign busy          = (state_q == SWEEP);
  assign done          = (state_q == DONE);
  assign tick_overrun  = overrun_q;

  // Sweep sequencing: IDLE -> SWEEP over all neurons -> one-cycle DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (commit) begin
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, sweep index and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (tick && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Neuron state; a same-cycle input write to the committed neuron overrides the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(N_NEURONS); k++) begin
        v_q[k]    <= '0;
        refr_q[k] <= 1'b0;
        pend_q[k] <= '0;
      end
    end else begin
      if (commit) begin
        v_q[idx_q]    <= v_n;
        refr_q[idx_q] <= refr_n;
        pend_q[idx_q] <= '0;
      end
      if (in_we) begin
        pend_q[in_addr] <= in_data;
      end
    end
  end

  // Event FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      end
    end
  end

  // Event FIFO storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PW-1:0]] <= idx_q;
    end
  end

`ifdef LIF_TDM_STATS_EN
  logic [15:0] spike_cnt_q;

  // Saturating count of pushed spike events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_cnt_q <= '0;
    end else if (push && (spike_cnt_q != 16'hFFFF)) begin
      spike_cnt_q <= spike_cnt_q + 16'd1;
    end
  end

  assign spike_cnt = spike_cnt_q;
`endif

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Self-checking bench for lif_tdm_scheduler (N_NEURONS=4, EVT_DEPTH=2).
module tb_lif_tdm_scheduler;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b1;
  logic           tick = 1'b0;
  logic           in_we = 1'b0;
  logic [IDW-1:0] in_addr = '0;
  logic [7:0]     in_data = '0;
  logic [IDW-1:0] rd_addr = '0;
  logic [7:0]     rd_v;
  logic           rd_refr;
  logic           busy, done, tick_overrun;
`ifdef LIF_TDM_STATS_EN
  logic [15:0]    spike_cnt;
`endif

  lif_tdm_scheduler_if #(.IDW(IDW)) evt ();

  lif_tdm_scheduler #(
    .N_NEURONS(N),
    .EVT_DEPTH(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .tick        (tick),
    .in_we       (in_we),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .rd_addr     (rd_addr),
    .rd_v        (rd_v),
    .rd_refr     (rd_refr),
    .evt         (evt),
    .busy        (busy),
    .done        (done),
    .tick_overrun(tick_overrun)
`ifdef LIF_TDM_STATS_EN
    ,
    .spike_cnt   (spike_cnt)
`endif
  );

  always #5 clk = ~clk;

  int             n_cmp = 0;
  int             n_bad = 0;
  logic [IDW-1:0] exp_q[$];

  // Scoreboard: every accepted event must match the next expected id.
  always @(negedge clk) begin
    if (rst_n && evt.evt_valid && evt.evt_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL evt_unexpected: got id %0d, required no event", evt.evt_id);
      end else begin
        logic [IDW-1:0] e;
        e = exp_q.pop_front();
        if (evt.evt_id !== e) begin
          n_bad++;
          $display("FAIL evt_id: got %0d, required %0d", evt.evt_id, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic write_in(input int id, input int data);
    in_we   = 1'b1;
    in_addr = IDW'(id);
    in_data = 8'(data);
    cyc();
    in_we   = 1'b0;
  endtask

  // Tick, wait (bounded) for done, then return to idle.
  task automatic run_sweep();
    int cnt;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cnt  = 1;
    while (done !== 1'b1 && cnt < 64) begin
      cyc();
      cnt++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL sweep_done_timeout: done=%b after %0d cycles, required 1", done, cnt);
    end
    cyc();
  endtask

  task automatic check_v(input string name, input int id, input int exp_v, input logic exp_r);
    rd_addr = IDW'(id);
    #1;
    n_cmp++;
    if (int'($signed(rd_v)) !== exp_v || rd_refr !== exp_r) begin
      n_bad++;
      $display("FAIL %s: id%0d V=%0d refr=%b, required V=%0d refr=%b",
               name, id, $signed(rd_v), rd_refr, exp_v, exp_r);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < int'(N); k++) check_v("reset_state", k, 0, 1'b0);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || evt.evt_valid !== 1'b0 || tick_overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: busy=%b done=%b valid=%b ovr=%b, required all 0",
               busy, done, evt.evt_valid, tick_overrun);
    end
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL sweep_cycle%0d: busy=%b done=%b, required busy=1 done=0", c, busy, done);
      end
      cyc();
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL done_cycle5: busy=%b done=%b, required busy=0 done=1", busy, done);
    end
    cyc();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse: done=%b on cycle 6, required 0", done);
    end
  endtask

  task automatic test_integrate();
    write_in(2, 32);
    run_sweep();
    check_v("integrate_v2", 2, 32, 1'b0);
    check_v("integrate_v0", 0, 0, 1'b0);
    n_cmp++;
    if (evt.evt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL integrate_no_evt: evt_valid=%b, required 0", evt.evt_valid);
    end
    run_sweep();
    check_v("consumed_v2", 2, 28, 1'b0);
  endtask

  task automatic test_spike_refractory();
    int vseq[11] = '{96, 68, 44, 23, 5, -11, -25, -37, -48, -58, -66};
    evt.evt_ready = 1'b1;
    write_in(1, 80);
    exp_q.push_back(2'd1);
    run_sweep();
    check_v("spike_v1", 1, 127, 1'b1);
    for (int t = 0; t < 11; t++) begin
      run_sweep();
      check_v($sformatf("refr_tick%0d", t + 1), 1, vseq[t], (t == 10) ? 1'b0 : 1'b1);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL spike_evt_seen: %0d events pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int cnt;
    apply_reset();
    evt.evt_ready = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      write_in(k, 100);
      exp_q.push_back(IDW'(k));
    end
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    for (int c = 0; c < 8; c++) cyc();
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || evt.evt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_stalled: busy=%b done=%b valid=%b, required 1 0 1",
               busy, done, evt.evt_valid);
    end
    check_v("bp_v0", 0, 127, 1'b1);
    check_v("bp_v1", 1, 127, 1'b1);
    check_v("bp_v2_held", 2, 0, 1'b0);
    evt.evt_ready = 1'b1;
    cnt = 0;
    while (done !== 1'b1 && cnt < 32) begin
      cyc();
      cnt++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_done_timeout: done=%b after %0d cycles, required 1", done, cnt);
    end
    cyc();
    cyc();
    check_v("bp_v3", 3, 127, 1'b1);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_all_events: %0d events pending, required 0", exp_q.size());
    end
`ifdef LIF_TDM_STATS_EN
    n_cmp++;
    if (spike_cnt !== 16'd4) begin
      n_bad++;
      $display("FAIL spike_cnt: got %0d, required 4", spike_cnt);
    end
`endif
  endtask

  task automatic test_overrun_reset();
    int ndone;
    apply_reset();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    n_cmp++;
    if (tick_overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_set: tick_overrun=%b, required 1", tick_overrun);
    end
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) ndone++;
      cyc();
    end
    n_cmp++;
    if (ndone != 1 || tick_overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_one_done: dones=%0d ovr=%b, required 1 and 1", ndone, tick_overrun);
    end
    // Reset in the middle of a sweep that has already queued a spike.
    evt.evt_ready = 1'b0;
    write_in(0, 100);
    write_in(1, 32);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || evt.evt_valid !== 1'b0 || tick_overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_outputs: busy=%b valid=%b ovr=%b, required all 0",
               busy, evt.evt_valid, tick_overrun);
    end
    for (int k = 0; k < int'(N); k++) check_v("midreset_state", k, 0, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();
    evt.evt_ready = 1'b1;
    run_sweep();
    check_v("midreset_pend_v0", 0, 0, 1'b0);
    check_v("midreset_pend_v1", 1, 0, 1'b0);
  endtask

  initial begin
    evt.evt_ready = 1'b1;
    test_reset();
    test_integrate();
    test_spike_refractory();
    test_backpressure();
    test_overrun_reset();
    cyc();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL final_scoreboard: %0d events pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
